// File: rtl/lc3_fetch_unit.sv
// LC-3 fetch/PC-update stage: resolves the previous instruction's control flow into the next fetch address.
// Latency: one cycle; addr_out and pc take their new values on the same edge that samples fetch_start.
// Backpressure: none; fetch_start may be held high for one fetch per cycle, and the outputs hold while it is low.
module lc3_fetch_unit (
    input  logic        clk,
    input  logic        rst_n,        // active-high asynchronous reset despite the name
    input  logic        fetch_start,
    input  logic [3:0]  opCode_in,
    input  logic [8:0]  offset_in,
    input  logic [15:0] reg_in,
    input  logic [2:0]  br_nzp,
    input  logic [2:0]  result_nzp,
    output logic [15:0] addr_out,
    output logic        wea_out,
    output logic [15:0] pc
);

    // Opcodes that redirect the fetch stream; every other opcode is sequential.
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_JSRR = 4'b0100;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    logic [15:0] offset_sext;
    logic [15:0] br_target;
    logic        br_taken;
    logic [15:0] target;

    // PCoffset9 is sign-extended, and the branch target wraps modulo 2^16.
    assign offset_sext = {{7{offset_in[8]}}, offset_in};
    assign br_target   = pc + offset_sext;

    // A BR is taken when any requested condition matches the current codes.
    // A mask of 000 therefore never branches.
    assign br_taken    = |(br_nzp & result_nzp);

    // Select the fetch target.
    // Non-control opcodes use only pc, so unused inputs cannot leak X into the outputs.
    always_comb begin
        target = pc;
        case (opCode_in)
            OP_BR:   target = br_taken ? br_target : pc;
            OP_JMP,
            OP_JSRR,
            OP_TRAP,
            OP_RTI:  target = reg_in;
            default: target = pc;
        endcase
    end

    // Reset clears the outputs asynchronously and takes priority over fetch_start.
    // A fetch issues target and advances pc past it.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            addr_out <= 16'h0000;
            pc       <= 16'h0000;
            wea_out  <= 1'b0;
        end else if (fetch_start) begin
            addr_out <= target;
            pc       <= target + 16'd1;
            wea_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Bench for lc3_fetch_unit: a reference model of the fetch rules feeds a scoreboard.
// Latency: each fetch is compared one cycle after it is driven; directed steps also check fixed values.
// Backpressure: none; the bench drives fetch_start freely.
module tb_lc3_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_start;
    logic [3:0]  opCode_in;
    logic [8:0]  offset_in;
    logic [15:0] reg_in;
    logic [2:0]  br_nzp;
    logic [2:0]  result_nzp;
    logic [15:0] addr_out;
    logic        wea_out;
    logic [15:0] pc;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] pc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_pc;
    int          n_cmp;
    int          n_err;

    lc3_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_start (fetch_start),
        .opCode_in   (opCode_in),
        .offset_in   (offset_in),
        .reg_in      (reg_in),
        .br_nzp      (br_nzp),
        .result_nzp  (result_nzp),
        .addr_out    (addr_out),
        .wea_out     (wea_out),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All comparisons go through this task.
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference target computation, written from the fetch rules.
    function automatic logic [15:0] model_target(input logic [3:0] op, input logic [8:0] off,
                                                 input logic [15:0] rin, input logic [2:0] brn,
                                                 input logic [2:0] res, input logic [15:0] cur_pc);
        logic [15:0] sext;
        sext = {{7{off[8]}}, off};
        case (op)
            4'b0000: model_target = ((brn & res) != 3'b000) ? cur_pc + sext : cur_pc;
            4'b1100, 4'b0100, 4'b1111, 4'b1000: model_target = rin;
            default: model_target = cur_pc;
        endcase
    endfunction

    // Drive one fetch at the falling edge, push the model result, then compare after the rising edge.
    task automatic do_fetch(input string tag, input logic [3:0] op, input logic [8:0] off,
                            input logic [15:0] rin, input logic [2:0] brn, input logic [2:0] res);
        exp_t e;
        exp_t got;
        @(negedge clk);
        opCode_in   = op;
        offset_in   = off;
        reg_in      = rin;
        br_nzp      = brn;
        result_nzp  = res;
        fetch_start = 1'b1;
        e.addr      = model_target(op, off, rin, brn, res, model_pc);
        e.pc        = e.addr + 16'd1;
        model_pc    = e.pc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 16'd0, 16'd1);
        end else begin
            got = sb.pop_front();
            check({tag, "_addr"}, addr_out, got.addr);
            check({tag, "_pc"}, pc, got.pc);
            check({tag, "_wea"}, {15'd0, wea_out}, 16'd0);
        end
    endtask

    // Compare the DUT outputs against fixed expected values.
    task automatic expect_out(input string tag, input logic [15:0] a, input logic [15:0] p);
        check({tag, "_addr_k"}, addr_out, a);
        check({tag, "_pc_k"}, pc, p);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        model_pc    = 16'h0000;
        rst_n       = 1'b1;
        fetch_start = 1'b0;
        opCode_in   = 4'b0000;
        offset_in   = 9'h000;
        reg_in      = 16'h0000;
        br_nzp      = 3'b000;
        result_nzp  = 3'b000;

        // Reset takes effect immediately, without waiting for a clock edge.
        #1;
        expect_out("rst_imm", 16'h0000, 16'h0000);
        check("rst_imm_wea", {15'd0, wea_out}, 16'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_out("rst_rel", 16'h0000, 16'h0000);
        check("rst_rel_wea", {15'd0, wea_out}, 16'd0);

        // Sequential fetches.
        do_fetch("seq1", 4'b0001, 9'h000, 16'h1234, 3'b000, 3'b000);
        expect_out("seq1", 16'h0000, 16'h0001);
        do_fetch("seq2", 4'b0001, 9'h000, 16'h1234, 3'b000, 3'b000);
        expect_out("seq2", 16'h0001, 16'h0002);

        // BRn taken with a positive offset, then with a negative offset.
        do_fetch("brn_pos", 4'b0000, 9'h005, 16'h0000, 3'b100, 3'b100);
        expect_out("brn_pos", 16'h0007, 16'h0008);
        do_fetch("brn_neg", 4'b0000, 9'h1FE, 16'h0000, 3'b100, 3'b100);
        expect_out("brn_neg", 16'h0006, 16'h0007);

        // Not taken: the mask does not match, and a mask of 000 never branches.
        do_fetch("brn_nt", 4'b0000, 9'h005, 16'h0000, 3'b100, 3'b010);
        expect_out("brn_nt", 16'h0007, 16'h0008);
        do_fetch("br_nop", 4'b0000, 9'h0FF, 16'h0000, 3'b000, 3'b001);
        expect_out("br_nop", 16'h0008, 16'h0009);

        // Idle: outputs hold while fetch_start is low.
        @(negedge clk);
        fetch_start = 1'b0;
        opCode_in   = 4'b1100;
        reg_in      = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        expect_out("idle", 16'h0008, 16'h0009);

        // JMP to 0xFFFF makes pc wrap, then a sequential fetch.
        do_fetch("jmp_wrap", 4'b1100, 9'h000, 16'hFFFF, 3'b000, 3'b000);
        expect_out("jmp_wrap", 16'hFFFF, 16'h0000);
        do_fetch("seq_wrap", 4'b0010, 9'h000, 16'hAAAA, 3'b000, 3'b000);
        expect_out("seq_wrap", 16'h0000, 16'h0001);

        // BR always taken with an offset that wraps below zero.
        do_fetch("br_under", 4'b0000, 9'h1FC, 16'h0000, 3'b111, 3'b010);
        expect_out("br_under", 16'hFFFD, 16'hFFFE);

        // The other register-indirect opcodes.
        do_fetch("jsrr", 4'b0100, 9'h000, 16'h4000, 3'b000, 3'b000);
        expect_out("jsrr", 16'h4000, 16'h4001);
        do_fetch("trap", 4'b1111, 9'h000, 16'h0025, 3'b000, 3'b000);
        expect_out("trap", 16'h0025, 16'h0026);
        do_fetch("rti", 4'b1000, 9'h000, 16'h3100, 3'b000, 3'b000);
        expect_out("rti", 16'h3100, 16'h3101);

        // Random back-to-back fetches checked against the model.
        for (int i = 0; i < 40; i++) begin
            do_fetch("rnd", 4'($urandom_range(0, 15)), 9'($urandom), 16'($urandom),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        // Reset mid-run: drive pc to 0x3005, then assert reset between edges.
        do_fetch("pre_rst", 4'b1100, 9'h000, 16'h3004, 3'b000, 3'b000);
        expect_out("pre_rst", 16'h3004, 16'h3005);
        @(posedge clk);
        #3;
        fetch_start = 1'b1;
        opCode_in   = 4'b1100;
        reg_in      = 16'h5555;
        rst_n       = 1'b1;
        #1;
        expect_out("rst_mid", 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        expect_out("rst_hold", 16'h0000, 16'h0000);
        @(negedge clk);
        fetch_start = 1'b0;
        rst_n       = 1'b0;
        model_pc    = 16'h0000;
        sb.delete();
        do_fetch("post_rst", 4'b0011, 9'h000, 16'h7777, 3'b000, 3'b000);
        expect_out("post_rst", 16'h0000, 16'h0001);

        @(negedge clk);
        fetch_start = 1'b0;
        check("sb_drained", 16'(sb.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
